// File: rtl/jt08_adpcmb_bridge_pkg.sv
// ============================================================================
// jt08_adpcmb_bridge_pkg
// Shared types and helpers for the YM2608 ADPCM-B RAM bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jt08_adpcmb_bridge_pkg;

   localparam int DEF_AW = 18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   // Odd byte addresses live on the upper lane of the 16-bit word.
   function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic odd);
      return odd ? word[15:8] : word[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/jt08_adpcmb_bridge_linebuf.sv
// ============================================================================
// jt08_adpcmb_bridge_linebuf
// One-word line buffer: tag/valid/data, hit compare, byte select, byte patch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt08_adpcmb_bridge_linebuf
   import jt08_adpcmb_bridge_pkg::*;
#(
   parameter int TW      = DEF_AW - 1,
   parameter bit USE_BUF = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_fill,
   input  logic [TW-1:0] i_fill_tag,
   input  logic [15:0]   i_fill_data,
   input  logic          i_patch,
   input  logic [TW-1:0] i_patch_tag,
   input  logic          i_patch_odd,
   input  logic [7:0]    i_patch_byte,
   input  logic [TW-1:0] i_look_tag,
   input  logic          i_look_odd,
   output logic          o_hit,
   output logic [7:0]    o_byte
);

   logic          r_valid;
   logic [TW-1:0] r_tag;
   logic [15:0]   r_data;
   logic          w_patch_hit;

   assign w_patch_hit = i_patch & r_valid & (r_tag == i_patch_tag);

   generate
      if (USE_BUF) begin : g_buf
         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_tag   <= '0;
               r_data  <= '0;
            end else if (i_fill) begin
               r_valid <= 1'b1;
               r_tag   <= i_fill_tag;
               r_data  <= i_fill_data;
            end else if (w_patch_hit) begin
               if (i_patch_odd) r_data[15:8] <= i_patch_byte;
               else             r_data[7:0]  <= i_patch_byte;
            end
         end
      end else begin : g_nobuf
         always_ff @(posedge clk) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
         end
      end
   endgenerate

   assign o_hit  = r_valid & (r_tag == i_look_tag);
   assign o_byte = lane_sel(r_data, i_look_odd);

endmodule

`default_nettype wire

// File: rtl/jt08_adpcmb_bridge.sv
// ============================================================================
// jt08_adpcmb_bridge
// YM2608 ADPCM-B RAM pins to 16-bit req/ack memory port, with line buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt08_adpcmb_bridge
   import jt08_adpcmb_bridge_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter bit USE_BUF = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cen,
   input  logic [23:0]   i_adpcmb_addr,
   input  logic          i_adpcmb_roe_n,
   input  logic          i_adpcmb_wr_n,
   input  logic [7:0]    i_adpcmb_dout,
   output logic [7:0]    o_adpcmb_din,
   output logic [AW-2:0] o_mem_addr,
   output logic [15:0]   o_mem_wdata,
   output logic [1:0]    o_mem_be,
   output logic          o_mem_we,
   output logic          o_mem_req,
   input  logic          i_mem_ack,
   input  logic [15:0]   i_mem_rdata,
   output logic          o_busy,
   output logic          o_ovf
);

   state_t          r_state, w_next;
   logic            r_roe_prev, r_wr_prev;
   logic [AW-1:0]   r_last_addr;
   logic            r_rd_pend, r_wr_pend;
   logic [AW-1:0]   r_rd_addr, r_wr_addr;
   logic [7:0]      r_wr_data;
   logic            r_hit_v;
   logic [7:0]      r_hit_byte, r_din;
   logic [AW-2:0]   r_mem_addr;
   logic [15:0]     r_mem_wdata;
   logic [1:0]      r_mem_be;
   logic            r_mem_we, r_ovf;

   logic [AW-1:0]   w_addr;
   logic            w_rd_stb, w_wr_stb, w_hit;
   logic [7:0]      w_hit_byte;
   logic            w_take_hit, w_issue_rd, w_issue_wr, w_rd_done, w_wr_done, w_rd_clr;
   logic            w_unused_addr;

   // Upper chip address bits wrap onto the RAM size.
   assign w_addr        = i_adpcmb_addr[AW-1:0];
   assign w_unused_addr = ^i_adpcmb_addr[23:AW];

   assign w_rd_stb = i_cen & ~i_adpcmb_roe_n & (r_roe_prev | (w_addr != r_last_addr));
   assign w_wr_stb = i_cen & r_wr_prev & ~i_adpcmb_wr_n;

   jt08_adpcmb_bridge_linebuf #(.TW(AW-1), .USE_BUF(USE_BUF)) u_linebuf (
      .clk          (clk),
      .rst          (rst),
      .i_fill       (w_rd_done),
      .i_fill_tag   (r_mem_addr),
      .i_fill_data  (i_mem_rdata),
      .i_patch      (w_wr_done),
      .i_patch_tag  (r_mem_addr),
      .i_patch_odd  (r_mem_be[1]),
      .i_patch_byte (r_mem_wdata[7:0]),
      .i_look_tag   (r_rd_addr[AW-1:1]),
      .i_look_odd   (r_rd_addr[0]),
      .o_hit        (w_hit),
      .o_byte       (w_hit_byte)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_take_hit = 1'b0;
      w_issue_rd = 1'b0;
      w_issue_wr = 1'b0;
      w_rd_done  = 1'b0;
      w_wr_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_wr_pend) begin
               w_next     = ST_WR;
               w_issue_wr = 1'b1;
            end else if (r_rd_pend) begin
               if (w_hit) begin
                  w_take_hit = 1'b1;
               end else begin
                  w_next     = ST_RD;
                  w_issue_rd = 1'b1;
               end
            end
         end
         ST_RD: if (i_mem_ack) begin
            w_next    = ST_IDLE;
            w_rd_done = 1'b1;
         end
         ST_WR: if (i_mem_ack) begin
            w_next    = ST_IDLE;
            w_wr_done = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_rd_clr = w_take_hit | w_rd_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_roe_prev  <= 1'b1;
         r_wr_prev   <= 1'b1;
         r_last_addr <= '0;
         r_rd_pend   <= 1'b0;
         r_rd_addr   <= '0;
         r_wr_pend   <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_hit_v     <= 1'b0;
         r_hit_byte  <= '0;
         r_din       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_mem_we    <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (i_cen) begin
            r_roe_prev <= i_adpcmb_roe_n;
            r_wr_prev  <= i_adpcmb_wr_n;
         end
         // A slot freeing on this same edge can take the new strobe.
         if (w_rd_stb) begin
            if (r_rd_pend && !w_rd_clr) begin
               r_ovf <= 1'b1;
            end else begin
               r_rd_pend   <= 1'b1;
               r_rd_addr   <= w_addr;
               r_last_addr <= w_addr;
            end
         end else if (w_rd_clr) begin
            r_rd_pend <= 1'b0;
         end
         if (w_wr_stb) begin
            if (r_wr_pend && !w_wr_done) begin
               r_ovf <= 1'b1;
            end else begin
               r_wr_pend <= 1'b1;
               r_wr_addr <= w_addr;
               r_wr_data <= i_adpcmb_dout;
            end
         end else if (w_wr_done) begin
            r_wr_pend <= 1'b0;
         end
         r_hit_v <= w_take_hit;
         if (w_take_hit) r_hit_byte <= w_hit_byte;
         if (r_hit_v)        r_din <= r_hit_byte;
         else if (w_rd_done) r_din <= lane_sel(i_mem_rdata, r_rd_addr[0]);
         if (w_issue_wr) begin
            r_mem_addr  <= r_wr_addr[AW-1:1];
            r_mem_we    <= 1'b1;
            r_mem_be    <= r_wr_addr[0] ? 2'b10 : 2'b01;
            r_mem_wdata <= {r_wr_data, r_wr_data};
         end else if (w_issue_rd) begin
            r_mem_addr  <= r_rd_addr[AW-1:1];
            r_mem_we    <= 1'b0;
            r_mem_be    <= 2'b11;
         end
      end
   end

   assign o_adpcmb_din = r_din;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_mem_be     = r_mem_be;
   assign o_mem_we     = r_mem_we;
   assign o_mem_req    = (r_state != ST_IDLE);
   assign o_busy       = (r_state != ST_IDLE) | r_rd_pend | r_wr_pend | r_hit_v;
   assign o_ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_jt08_adpcmb_bridge.sv
// ============================================================================
// tb_jt08_adpcmb_bridge
// Self-checking bench: memory responder plus byte-level reference memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jt08_adpcmb_bridge;

   logic        clk, rst, cen;
   logic [23:0] addr;
   logic        roe_n, wr_n;
   logic [7:0]  dout, din;
   logic [16:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [1:0]  mem_be;
   logic        mem_we, mem_req, mem_ack, spur_ack, busy, ovf;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:131071];
   logic [7:0]  ref_b [int];
   int          resp_lat = 3;
   int          req_count = 0;
   logic        resp_active = 1'b0;
   logic [16:0] cap_addr;
   logic        cap_we;
   logic [1:0]  cap_be;
   logic [15:0] cap_wdata;
   logic        we_log [$];

   jt08_adpcmb_bridge #(.AW(18), .USE_BUF(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_cen          (cen),
      .i_adpcmb_addr  (addr),
      .i_adpcmb_roe_n (roe_n),
      .i_adpcmb_wr_n  (wr_n),
      .i_adpcmb_dout  (dout),
      .o_adpcmb_din   (din),
      .o_mem_addr     (mem_addr),
      .o_mem_wdata    (mem_wdata),
      .o_mem_be       (mem_be),
      .o_mem_we       (mem_we),
      .o_mem_req      (mem_req),
      .i_mem_ack      (mem_ack | spur_ack),
      .i_mem_rdata    (mem_rdata),
      .o_busy         (busy),
      .o_ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Memory responder: latches the request, acks after resp_lat cycles.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            resp_active = 1'b1;
            cap_addr  = mem_addr;
            cap_we    = mem_we;
            cap_be    = mem_be;
            cap_wdata = mem_wdata;
            req_count++;
            we_log.push_back(cap_we);
            for (int k = 1; k < resp_lat; k++) begin
               @(negedge clk);
               if (mem_req === 1'b1) begin
                  checks++;
                  if ({mem_addr, mem_we, mem_be, mem_wdata} !== {cap_addr, cap_we, cap_be, cap_wdata}) begin
                     errors++;
                     $display("FAIL req_stable got %h/%b/%b/%h required %h/%b/%b/%h",
                              mem_addr, mem_we, mem_be, mem_wdata, cap_addr, cap_we, cap_be, cap_wdata);
                  end
               end
            end
            if (cap_we) begin
               if (cap_be[0]) mem[cap_addr][7:0]  = cap_wdata[7:0];
               if (cap_be[1]) mem[cap_addr][15:8] = cap_wdata[15:8];
            end
            mem_rdata = mem[cap_addr];
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL req_drop got %b required 0", mem_req);
            end
            resp_active = 1'b0;
         end
      end
   end

   task automatic do_read(input logic [23:0] a);
      @(negedge clk);
      addr  = a;
      roe_n = 1'b0;
      @(negedge clk);
      roe_n = 1'b1;
   endtask

   task automatic do_write(input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a;
      dout = d;
      wr_n = 1'b0;
      @(negedge clk);
      wr_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout busy=%b required 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cen = 1'b1; addr = 24'h0; roe_n = 1'b0; wr_n = 1'b1; dout = 8'h00; spur_ack = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_req, din, busy, ovf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got req=%b din=%h busy=%b ovf=%b required 0/00/0/0", mem_req, din, busy, ovf);
      end
      rst   = 1'b0;
      roe_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (req_count !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_req got req_count=%0d busy=%b required 0/0", req_count, busy);
      end
   endtask

   task automatic test_miss_hit();
      int rc;
      mem[17'h00100] = 16'hBEEF;
      resp_lat = 5;
      rc = req_count;
      do_read(24'h000200);
      wait_idle("miss");
      checks++;
      if (din !== 8'hEF || req_count !== rc + 1) begin
         errors++;
         $display("FAIL miss_data got din=%h reqs=%0d required EF/%0d", din, req_count - rc, 1);
      end
      do_read(24'h000201);
      @(negedge clk);
      checks++;
      if (din !== 8'hEF) begin
         errors++;
         $display("FAIL hit_early got %h required EF", din);
      end
      @(negedge clk);
      checks++;
      if (din !== 8'hBE || req_count !== rc + 1) begin
         errors++;
         $display("FAIL hit_data got din=%h reqs=%0d required BE/1", din, req_count - rc);
      end
   endtask

   task automatic test_write_patch();
      int rc;
      resp_lat = 3;
      rc = req_count;
      do_write(24'h000201, 8'h5A);
      wait_idle("write");
      checks++;
      if ({cap_we, cap_be, cap_wdata} !== {1'b1, 2'b10, 16'h5A5A} || cap_addr !== 17'h00100) begin
         errors++;
         $display("FAIL write_req got we=%b be=%b wdata=%h addr=%h required 1/10/5A5A/00100",
                  cap_we, cap_be, cap_wdata, cap_addr);
      end
      rc = req_count;
      do_read(24'h000201);
      wait_idle("patch_rd");
      checks++;
      if (din !== 8'h5A || req_count !== rc) begin
         errors++;
         $display("FAIL patch_hit got din=%h new_reqs=%0d required 5A/0", din, req_count - rc);
      end
      do_read(24'h000200);
      wait_idle("patch_rd0");
      checks++;
      if (din !== 8'hEF || req_count !== rc) begin
         errors++;
         $display("FAIL patch_other got din=%h new_reqs=%0d required EF/0", din, req_count - rc);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] d;
      d = 8'($urandom_range(1, 255));
      mem[17'h00180] = 16'h0000;
      we_log.delete();
      @(negedge clk);
      addr = 24'h000300; dout = d; roe_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      roe_n = 1'b1; wr_n = 1'b1;
      wait_idle("simul");
      checks++;
      if (we_log.size() != 2) begin
         errors++;
         $display("FAIL simul_count got %0d required 2", we_log.size());
      end else begin
         checks++;
         if (we_log[0] !== 1'b1 || we_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL simul_order got we %b,%b required 1,0", we_log[0], we_log[1]);
         end
      end
      checks++;
      if (din !== d) begin
         errors++;
         $display("FAIL simul_data got %h required %h", din, d);
      end
   endtask

   task automatic test_cen_gate();
      int rc;
      rc = req_count;
      @(negedge clk);
      cen = 1'b0; addr = 24'h000600; roe_n = 1'b0;
      repeat (3) @(negedge clk);
      roe_n = 1'b1;
      repeat (2) @(negedge clk);
      cen = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_count !== rc) begin
         errors++;
         $display("FAIL cen_gate got busy=%b new_reqs=%0d required 0/0", busy, req_count - rc);
      end
   endtask

   task automatic test_idle_ack();
      logic [7:0] d0;
      d0 = din;
      @(negedge clk);
      spur_ack = 1'b1;
      @(negedge clk);
      spur_ack = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (din !== d0 || busy !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_ack got din=%h busy=%b req=%b required %h/0/0", din, busy, mem_req, d0);
      end
   endtask

   task automatic test_random();
      logic [23:0] a;
      logic [15:0] v;
      logic [7:0]  d;
      for (int w = 17'h00800; w < 17'h00820; w++) begin
         v = 16'($urandom);
         mem[w] = v;
         ref_b[2*w]     = v[7:0];
         ref_b[2*w + 1] = v[15:8];
      end
      a = 24'h001000;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) a = a ^ 24'h1;
         else a = 24'h001000 + 24'($urandom_range(0, 63));
         resp_lat = $urandom_range(1, 6);
         if ($urandom_range(0, 2) == 0) begin
            d = 8'($urandom);
            do_write(a, d);
            ref_b[int'(a)] = d;
            wait_idle("rnd_wr");
         end else begin
            do_read(a);
            wait_idle("rnd_rd");
            checks++;
            if (din !== ref_b[int'(a)]) begin
               errors++;
               $display("FAIL rnd_read addr=%h got %h required %h", a, din, ref_b[int'(a)]);
            end
         end
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL rnd_ovf got %b required 0", ovf);
      end
   endtask

   task automatic test_overflow();
      mem[17'h00200] = 16'h1234;
      mem[17'h00201] = 16'h5678;
      mem[17'h00202] = 16'h9ABC;
      resp_lat = 20;
      do_read(24'h000400);
      repeat (3) @(negedge clk);
      do_read(24'h000402);
      repeat (3) @(negedge clk);
      do_read(24'h000404);
      @(negedge clk);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got %b required 1", ovf);
      end
      wait_idle("ovf");
      repeat (5) @(negedge clk);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got %b required 1", ovf);
      end
   endtask

   task automatic test_midop_reset_wrap();
      int n;
      resp_lat = 15;
      do_read(24'h000500);
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL midop_req got %b required 1", mem_req);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL midop_drop got %b required 0", mem_req);
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (resp_active === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (din !== 8'h00 || busy !== 1'b0 || ovf !== 1'b0 || resp_active !== 1'b0) begin
         errors++;
         $display("FAIL midop_after got din=%h busy=%b ovf=%b resp=%b required 00/0/0/0",
                  din, busy, ovf, resp_active);
      end
      resp_lat = 2;
      do_read(24'hFC0200);
      wait_idle("wrap");
      checks++;
      if (cap_addr !== 17'h00100 || din !== 8'hEF) begin
         errors++;
         $display("FAIL wrap got addr=%h din=%h required 00100/EF", cap_addr, din);
      end
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_write_patch();
      test_simultaneous();
      test_cen_gate();
      test_idle_ack();
      test_random();
      test_overflow();
      test_midop_reset_wrap();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
